// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction Fetch stage feeding the Instruction Decode stage. Holds the PC,
//   issues one instruction-memory request at a time over a req/ready handshake,
//   and delivers instruction, PC and PC+4 to decode. While memory stalls it
//   inserts NOP bubbles. Decode may redirect the PC (the redirect takes effect
//   after the delay slot) or freeze the stage (outputs hold, nothing new issued).
//
// Ports
//   CLK                 in   rising-edge clock
//   RESET               in   synchronous, active-high reset
//   Alt_PC_IN           in   redirect target from decode
//   Request_Alt_PC_IN   in   redirect request from decode (sampled every cycle)
//   WANT_FREEZE_IN      in   decode freeze request
//   IMem_Req            out  fetch request valid
//   IMem_Addr           out  fetch address (current PC)
//   IMem_Ready          in   memory response valid for IMem_Addr this cycle
//   IMem_Data           in   instruction word, valid with IMem_Ready
//   Instr1_OUT          out  instruction to decode (NOP_INSTR for a bubble)
//   Instr_PC_OUT        out  PC of Instr1_OUT
//   Instr_PC_Plus4_OUT  out  Instr_PC_OUT + 4
//   Fetch_Count         out  instructions delivered to decode (wraps)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic [31:0] Fetch_Count
);

  // RUN: a request is outstanding. FULL: a fetched word waits in the buffer
  // because decode was frozen when it arrived; no request is issued.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] target_r;
  logic        redirect_pending_r;
  logic [31:0] buf_data_r;
  logic [31:0] buf_pc_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;

  assign pc_plus4_s = pc_r + 32'd4;

  // Request is gated by RESET so an in-flight fetch is dropped in the reset cycle.
  assign IMem_Req  = (state_r == RUN) && !RESET;
  assign IMem_Addr = pc_r;

  // PC to fetch after the current handshake: a live redirect wins over a stored one.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (Request_Alt_PC_IN) begin
      next_pc_s = Alt_PC_IN;
    end else if (redirect_pending_r) begin
      next_pc_s = target_r;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Fetch control, PC, redirect capture, freeze buffer and decode-facing outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r            <= RUN;
      pc_r               <= RESET_PC;
      target_r           <= 32'h00000000;
      redirect_pending_r <= 1'b0;
      buf_data_r         <= NOP_INSTR;
      buf_pc_r           <= 32'h00000000;
      Instr1_OUT         <= NOP_INSTR;
      Instr_PC_OUT       <= 32'h00000000;
      Instr_PC_Plus4_OUT <= 32'h00000000;
      Fetch_Count        <= 32'h00000000;
    end else begin
      case (state_r)
        RUN: begin
          if (IMem_Ready) begin
            // The word handshaking now is the delay slot; the redirect
            // only steers the address of the following fetch.
            pc_r               <= next_pc_s;
            redirect_pending_r <= 1'b0;
            if (!WANT_FREEZE_IN) begin
              Instr1_OUT         <= IMem_Data;
              Instr_PC_OUT       <= pc_r;
              Instr_PC_Plus4_OUT <= pc_plus4_s;
              Fetch_Count        <= Fetch_Count + 32'd1;
            end else begin
              buf_data_r <= IMem_Data;
              buf_pc_r   <= pc_r;
              state_r    <= FULL;
            end
          end else begin
            // Address must stay put until Ready, so a redirect is parked.
            if (Request_Alt_PC_IN) begin
              redirect_pending_r <= 1'b1;
              target_r           <= Alt_PC_IN;
            end else begin
              redirect_pending_r <= redirect_pending_r;
            end
            if (!WANT_FREEZE_IN) begin
              Instr1_OUT <= NOP_INSTR;
            end else begin
              Instr1_OUT <= Instr1_OUT;
            end
          end
        end

        FULL: begin
          // Nothing is outstanding, so a redirect can retarget the PC at once.
          if (Request_Alt_PC_IN) begin
            pc_r <= Alt_PC_IN;
          end else begin
            pc_r <= pc_r;
          end
          if (!WANT_FREEZE_IN) begin
            Instr1_OUT         <= buf_data_r;
            Instr_PC_OUT       <= buf_pc_r;
            Instr_PC_Plus4_OUT <= buf_pc_r + 32'd4;
            Fetch_Count        <= Fetch_Count + 32'd1;
            state_r            <= RUN;
          end else begin
            state_r <= FULL;
          end
        end

        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

endmodule
